// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: dcache and icache share a single RAM port.
// Data requests win over instruction requests. A grant is held until the RAM
// reports ACCESS (completed), ERROR (retry via IDLE) or the requester drops.
// Optional feature macro: MEM_ARBITER_IFAIR_EN adds instruction anti-starvation
// (after three completed data accesses with iREN pending, IGRANT wins once).
//
// state  | meaning
// IDLE   | no grant; RAM strobes low, address/data zero, both waits high
// DGRANT | dcache owns the RAM port
// IGRANT | icache owns the RAM port
module mem_arbiter (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  state_t state_q, state_d;
  logic   d_req;
  logic   ram_done;
  logic   ram_err;

  assign d_req    = dREN | dWEN;
  assign ram_done = (ramstate == RAM_ACCESS);
  assign ram_err  = (ramstate == RAM_ERROR);

`ifdef MEM_ARBITER_IFAIR_EN
  logic [1:0] starve_q, starve_d;

  // Count data completions that happened while the icache was waiting.
  always_comb begin
    starve_d = starve_q;
    if (state_q == DGRANT && d_req && ram_done && iREN && starve_q != 2'd3) begin
      starve_d = starve_q + 2'd1;
    end else if (state_q == IGRANT && iREN && ram_done) begin
      starve_d = 2'd0;
    end
  end
`endif

  // Arbitration and grant release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
`ifdef MEM_ARBITER_IFAIR_EN
        if (starve_q == 2'd3 && iREN) begin
          state_d = IGRANT;
        end else if (d_req) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
`else
        if (d_req) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
`endif
      end
      DGRANT: begin
        if (!d_req || ram_done || ram_err) state_d = IDLE;
      end
      IGRANT: begin
        if (!iREN || ram_done || ram_err) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight access.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
`ifdef MEM_ARBITER_IFAIR_EN
      starve_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_ARBITER_IFAIR_EN
      starve_q <= starve_d;
`endif
    end
  end

  // RAM port steering; reset forces the idle view even before the edge.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    if (nRST) begin
      case (state_q)
        DGRANT: begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          dwait    = ~(d_req & ram_done);
        end
        IGRANT: begin
          ramaddr = iaddr;
          ramREN  = iREN;
          iwait   = ~(iREN & ram_done);
        end
        default: ;
      endcase
    end
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared against an ownership-based reference model.
module tb_mem_arbiter;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN),
    .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .iwait(iwait),
    .dwait(dwait), .iload(iload), .dload(dload), .ramREN(ramREN),
    .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: who owns the RAM port (0 none, 1 dcache, 2 icache)
  // and how many data accesses finished while the icache waited.
  int owner = 0;
  int starve = 0;

  always @(posedge CLK) begin
    int nxt;
    bit dq;
    bit fin;
    dq  = dREN | dWEN;
    fin = (ramstate == 2'd2);
    nxt = owner;
    if (!nRST) begin
      nxt = 0;
      starve = 0;
    end else if (owner == 0) begin
`ifdef MEM_ARBITER_IFAIR_EN
      if (starve == 3 && iREN) nxt = 2;
      else if (dq) nxt = 1;
      else if (iREN) nxt = 2;
`else
      if (dq) nxt = 1;
      else if (iREN) nxt = 2;
`endif
    end else if (owner == 1) begin
      if (!dq || ramstate >= 2'd2) nxt = 0;
      if (dq && fin && iREN && starve < 3) starve = starve + 1;
    end else begin
      if (!iREN || ramstate >= 2'd2) nxt = 0;
      if (iREN && fin) starve = 0;
    end
    owner = nxt;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = 2'd0;
  endtask

  task automatic apply_reset();
    nRST = 0;
    clear_inputs();
    tick();
    tick();
    nRST = 1;
  endtask

  task automatic test_reset();
    nRST = 0;
    clear_inputs();
    iREN = 1; dWEN = 1; daddr = 32'h55; dstore = 32'hAA; ramstate = 2'd2;
    tick();
    tick();
    @(negedge CLK);
    checks++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100 || ramaddr !== 0 || ramstore !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got iwait=%b dwait=%b ren=%b wen=%b addr=%h store=%h, want 1 1 0 0 0 0",
               iwait, dwait, ramREN, ramWEN, ramaddr, ramstore);
    end
    tick();
    nRST = 1;
    clear_inputs();
    @(negedge CLK);
    checks++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100 || ramaddr !== 0) begin
      errors++;
      $display("FAIL after_reset_idle: got iwait=%b dwait=%b ren=%b wen=%b addr=%h, want 1 1 0 0 0",
               iwait, dwait, ramREN, ramWEN, ramaddr);
    end
    tick();
  endtask

  task automatic test_ifetch();
    clear_inputs();
    iREN = 1; iaddr = 32'h40; ramstate = 2'd1;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || iwait !== 1'b1) begin
      errors++;
      $display("FAIL ifetch_c0: got ren=%b iwait=%b, want 0 1", ramREN, iwait);
    end
    for (int c = 1; c <= 2; c++) begin
      tick();
      @(negedge CLK);
      checks++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1 || ramWEN !== 1'b0) begin
        errors++;
        $display("FAIL ifetch_busy_c%0d: got ren=%b addr=%h iwait=%b wen=%b, want 1 00000040 1 0",
                 c, ramREN, ramaddr, iwait, ramWEN);
      end
    end
    tick();
    ramstate = 2'd2; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    checks++;
    if (iwait !== 1'b0 || iload !== 32'hDEADBEEF || dload !== 32'hDEADBEEF || dwait !== 1'b1) begin
      errors++;
      $display("FAIL ifetch_c3: got iwait=%b iload=%h dload=%h dwait=%b, want 0 deadbeef deadbeef 1",
               iwait, iload, dload, dwait);
    end
    tick();
    clear_inputs();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || iwait !== 1'b1) begin
      errors++;
      $display("FAIL ifetch_release: got ren=%b iwait=%b, want 0 1", ramREN, iwait);
    end
    tick();
  endtask

  task automatic test_priority();
    clear_inputs();
    iREN = 1; dREN = 1; daddr = 32'h100; iaddr = 32'h200; ramstate = 2'd1;
    @(negedge CLK);
    tick();
    ramstate = 2'd2;
    @(negedge CLK);
    checks++;
    if (ramaddr !== 32'h100 || ramREN !== 1'b1 || dwait !== 1'b0 || iwait !== 1'b1) begin
      errors++;
      $display("FAIL prio_dgrant: got addr=%h ren=%b dwait=%b iwait=%b, want 00000100 1 0 1",
               ramaddr, ramREN, dwait, iwait);
    end
    tick();
    dREN = 0; ramstate = 2'd0;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || ramaddr !== 32'h0 || iwait !== 1'b1) begin
      errors++;
      $display("FAIL prio_bubble: got ren=%b addr=%h iwait=%b, want 0 0 1", ramREN, ramaddr, iwait);
    end
    tick();
    ramstate = 2'd2;
    @(negedge CLK);
    checks++;
    if (ramaddr !== 32'h200 || ramREN !== 1'b1 || iwait !== 1'b0) begin
      errors++;
      $display("FAIL prio_igrant: got addr=%h ren=%b iwait=%b, want 00000200 1 0", ramaddr, ramREN, iwait);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_write();
    clear_inputs();
    dWEN = 1; dREN = 1; daddr = 32'h80; dstore = 32'h12345678; ramstate = 2'd2;
    @(negedge CLK);
    checks++;
    if (ramWEN !== 1'b0 || dwait !== 1'b1) begin
      errors++;
      $display("FAIL write_c0: got wen=%b dwait=%b, want 0 1", ramWEN, dwait);
    end
    tick();
    @(negedge CLK);
    checks++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h12345678 || ramaddr !== 32'h80 || dwait !== 1'b0) begin
      errors++;
      $display("FAIL write_c1: got wen=%b ren=%b store=%h addr=%h dwait=%b, want 1 0 12345678 00000080 0",
               ramWEN, ramREN, ramstore, ramaddr, dwait);
    end
    tick();
    @(negedge CLK);
    checks++;
    if (ramWEN !== 1'b0 || dwait !== 1'b1 || ramstore !== 32'h0) begin
      errors++;
      $display("FAIL write_c2: got wen=%b dwait=%b store=%h, want 0 1 0", ramWEN, dwait, ramstore);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_error_retry();
    clear_inputs();
    iREN = 1; iaddr = 32'hC0;
    tick();
    ramstate = 2'd3;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || iwait !== 1'b1) begin
      errors++;
      $display("FAIL err_grant: got ren=%b iwait=%b, want 1 1", ramREN, iwait);
    end
    tick();
    ramstate = 2'd0;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b0 || iwait !== 1'b1) begin
      errors++;
      $display("FAIL err_idle: got ren=%b iwait=%b, want 0 1", ramREN, iwait);
    end
    tick();
    ramstate = 2'd2;
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'hC0 || iwait !== 1'b0) begin
      errors++;
      $display("FAIL err_retry: got ren=%b addr=%h iwait=%b, want 1 000000c0 0", ramREN, ramaddr, iwait);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    clear_inputs();
    dREN = 1; daddr = 32'h300; ramstate = 2'd1;
    tick();
    @(negedge CLK);
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin
      errors++;
      $display("FAIL rst_mid_pre: got ren=%b addr=%h, want 1 00000300", ramREN, ramaddr);
    end
    nRST = 0;
    tick();
    nRST = 1;
    dREN = 0;
    @(negedge CLK);
    checks++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100 || ramaddr !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_post: got iwait=%b dwait=%b ren=%b wen=%b addr=%h, want 1 1 0 0 0",
               iwait, dwait, ramREN, ramWEN, ramaddr);
    end
    tick();
  endtask

  task automatic test_fairness();
    // grant code per cycle: 0 idle, 1 data, 2 instr
    int exp_seq [8];
`ifdef MEM_ARBITER_IFAIR_EN
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 2};
`else
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    apply_reset();
    clear_inputs();
    dREN = 1; iREN = 1; daddr = 32'hD0; iaddr = 32'hE0; ramstate = 2'd2;
    for (int c = 0; c < 8; c++) begin
      int got;
      @(negedge CLK);
      got = (ramREN && ramaddr == 32'hD0 && !dwait) ? 1 :
            (ramREN && ramaddr == 32'hE0 && !iwait) ? 2 :
            (!ramREN && iwait && dwait) ? 0 : 3;
      checks++;
      if (got !== exp_seq[c]) begin
        errors++;
        $display("FAIL fair_c%0d: got grant=%0d, want %0d", c, got, exp_seq[c]);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      bit dq;
      logic [31:0] e_addr, e_store;
      logic e_ren, e_wen, e_iw, e_dw;
      nRST     = ($urandom_range(0, 49) != 0);
      iREN     = ($urandom_range(0, 9) < 7);
      dREN     = ($urandom_range(0, 9) < 4);
      dWEN     = ($urandom_range(0, 9) < 2);
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      @(negedge CLK);
      dq = dREN | dWEN;
      e_addr = 0; e_store = 0; e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
      if (nRST && owner == 1) begin
        e_addr = daddr; e_store = dstore;
        e_wen = dWEN; e_ren = dREN && !dWEN;
        e_dw = !(dq && ramstate == 2'd2);
      end else if (nRST && owner == 2) begin
        e_addr = iaddr; e_ren = iREN;
        e_iw = !(iREN && ramstate == 2'd2);
      end
      checks++;
      if (ramaddr !== e_addr || ramstore !== e_store) begin
        errors++;
        $display("FAIL rnd_addr_data c%0d: got addr=%h store=%h, want %h %h", c, ramaddr, ramstore, e_addr, e_store);
      end
      checks++;
      if (ramREN !== e_ren || ramWEN !== e_wen) begin
        errors++;
        $display("FAIL rnd_strobes c%0d: got ren=%b wen=%b, want %b %b", c, ramREN, ramWEN, e_ren, e_wen);
      end
      checks++;
      if (iwait !== e_iw || dwait !== e_dw) begin
        errors++;
        $display("FAIL rnd_waits c%0d: got iwait=%b dwait=%b, want %b %b", c, iwait, dwait, e_iw, e_dw);
      end
      checks++;
      if (iload !== ramload || dload !== ramload) begin
        errors++;
        $display("FAIL rnd_loads c%0d: got iload=%h dload=%h, want %h", c, iload, dload, ramload);
      end
      tick();
    end
    nRST = 1;
    clear_inputs();
    tick();
  endtask

  initial begin
    nRST = 0;
    clear_inputs();
    test_reset();
    test_ifetch();
    test_priority();
    test_write();
    test_error_retry();
    test_reset_mid_grant();
    test_fairness();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
